// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-master data-memory arbiter: master indices and the
// per-master request bundle, sized for the widest configuration supported.
package dmem_arb_pkg;

    typedef enum logic {
        MST_CORE   = 1'b0,
        MST_LOADER = 1'b1
    } mst_e;

    localparam int DEFAULT_MAX_WAIT = 4;

    localparam int REQ_ADDR_W = 64;
    localparam int REQ_DATA_W = 64;
    localparam int REQ_BE_W   = REQ_DATA_W / 8;

    typedef struct packed {
        logic                  we;
        logic [REQ_BE_W-1:0]   be;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic mst_e gnt_owner(input logic [1:0] gnt);
        return gnt[1] ? MST_LOADER : MST_CORE;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker with M1 burst lock and a starvation break for M0.
// Produces a one-hot (or empty) grant vector purely from the current state.
module arb_rr2
    import dmem_arb_pkg::*;
(
    input  logic       i_en,
    input  logic [1:0] i_req,
    input  logic       i_lock,
    input  logic       i_wait_sat,
    input  mst_e       i_last,
    output logic [1:0] o_gnt
);

    logic w_break;

    assign w_break = i_lock && i_req[0] && i_wait_sat;

    // NOTE: o_gnt gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        o_gnt = 2'b00;
        if (!i_en) begin
            o_gnt = 2'b00;
        end else if (w_break) begin
            o_gnt = 2'b01;
        end else if (i_lock && i_req[1]) begin
            o_gnt = 2'b10;
        end else if (i_req == 2'b01) begin
            o_gnt = 2'b01;
        end else if (i_req == 2'b10) begin
            o_gnt = 2'b10;
        end else if (i_req == 2'b11) begin
            o_gnt = (i_last == MST_CORE) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single dmem port between the core (M0) and the debug loader (M1),
// muxing the granted request onto memory and registering each master's read data.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [DATA_W/8-1:0] m0_be,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [DATA_W/8-1:0] m1_be,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic                m1_lock,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wd,
    input  logic [DATA_W-1:0]   mem_rd
);

    localparam int         BE_W     = DATA_W / 8;
    localparam logic [3:0] WAIT_SAT = 4'(MAX_WAIT);

    mem_req_t    w_m0;
    mem_req_t    w_m1;
    mem_req_t    w_sel;
    logic [1:0]  w_gnt;
    logic        w_any_gnt;
    logic        w_wait_sat;

    logic        r_lock;
    mst_e        r_last;
    logic [3:0]  r_wait;
    logic        r_m0_rvalid;
    logic        r_m1_rvalid;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;

    always_comb begin
        w_m0.we    = m0_we;
        w_m0.be    = REQ_BE_W'(m0_be);
        w_m0.addr  = REQ_ADDR_W'(m0_addr);
        w_m0.wdata = REQ_DATA_W'(m0_wdata);
        w_m1.we    = m1_we;
        w_m1.be    = REQ_BE_W'(m1_be);
        w_m1.addr  = REQ_ADDR_W'(m1_addr);
        w_m1.wdata = REQ_DATA_W'(m1_wdata);
    end

    assign w_wait_sat = (r_wait == WAIT_SAT);

    arb_rr2 u_arb (
        .i_en       (reset),
        .i_req      ({m1_req, m0_req}),
        .i_lock     (r_lock),
        .i_wait_sat (w_wait_sat),
        .i_last     (r_last),
        .o_gnt      (w_gnt)
    );

    assign w_any_gnt = |w_gnt;
    assign m0_gnt    = w_gnt[0];
    assign m1_gnt    = w_gnt[1];

    // The request path follows M0 whenever M1 is not the granted master.
    assign w_sel    = w_gnt[1] ? w_m1 : w_m0;
    assign mem_we   = w_any_gnt && w_sel.we;
    assign mem_be   = BE_W'(w_sel.be);
    assign mem_addr = ADDR_W'(w_sel.addr);
    assign mem_wd   = DATA_W'(w_sel.wdata);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last <= MST_LOADER;
            r_lock <= 1'b0;
        end else begin
            if (w_any_gnt) begin
                r_last <= gnt_owner(w_gnt);
            end
            if (w_gnt[1]) begin
                r_lock <= m1_lock;
            end else if (r_lock && (w_gnt[0] || !m1_req)) begin
                r_lock <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait <= 4'd0;
        end else if (m0_req && !w_gnt[0]) begin
            if (!w_wait_sat) begin
                r_wait <= r_wait + 4'd1;
            end
        end else begin
            r_wait <= 4'd0;
        end
    end

    // NOTE: read-data holders are ordinary flops, not a RAM, so they take the reset value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_m0_rvalid <= w_gnt[0] && !m0_we;
            r_m1_rvalid <= w_gnt[1] && !m1_we;
            if (w_gnt[0] && !m0_we) begin
                r_m0_rdata <= mem_rd;
            end
            if (w_gnt[1] && !m1_we) begin
                r_m1_rdata <= mem_rd;
            end
        end
    end

    assign m0_rvalid = r_m0_rvalid;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rvalid = r_m1_rvalid;
    assign m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-enabled behavioural dmem behind it.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we;
    logic [3:0]  m0_be;
    logic [31:0] m0_addr, m0_wdata;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_lock;
    logic [3:0]  m1_be;
    logic [31:0] m1_addr, m1_wdata;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wd[8*b +: 8];
            end
        end
    end

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_be = 4'h0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_be = 4'h0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
    endtask

    task automatic set_m0(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata);
        m0_req = 1; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
    endtask

    task automatic set_m1(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic lock);
        m1_req = 1; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
    endtask

    task automatic m1_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        idle();
        set_m1(1'b1, be, addr, data, 1'b0);
        tick();
        idle();
    endtask

    task automatic test_reset();
        reset = 0;
        idle();
        set_m0(1'b1, 4'hF, 32'h40, 32'h0);
        set_m1(1'b0, 4'hF, 32'h80, 32'h0, 1'b0);
        @(negedge clk);
        checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL reset_m0_gnt got %b exp 0", m0_gnt); end
        checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL reset_m1_gnt got %b exp 0", m1_gnt); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
        tick();
        tick();
        checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL reset_m0_rvalid got %b exp 0", m0_rvalid); end
        checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_m1_rvalid got %b exp 0", m1_rvalid); end
        checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL reset_m0_rdata got %h exp 0", m0_rdata); end
        checks++; if (m1_rdata !== 32'h0) begin errors++; $display("FAIL reset_m1_rdata got %h exp 0", m1_rdata); end
        reset = 1;
        m0_we = 0;
        @(negedge clk);
        checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL release_m0_gnt got %b exp 1", m0_gnt); end
        checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL release_m1_gnt got %b exp 0", m1_gnt); end
        tick();
        idle();
    endtask

    task automatic test_single_read();
        m1_write(32'h40, 32'hDEADBEEF, 4'hF);
        checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL write_no_rvalid got %b exp 0", m1_rvalid); end
        set_m0(1'b0, 4'hF, 32'h40, 32'h0);
        @(negedge clk);
        checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL read_m0_gnt got %b exp 1", m0_gnt); end
        checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL read_mem_addr got %h exp 40", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL read_mem_we got %b exp 0", mem_we); end
        tick();
        idle();
        checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL read_m0_rvalid got %b exp 1", m0_rvalid); end
        checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_m0_rdata got %h exp deadbeef", m0_rdata); end
        checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL read_m1_rvalid got %b exp 0", m1_rvalid); end
        tick();
        checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse got %b exp 0", m0_rvalid); end
        checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold got %h exp deadbeef", m0_rdata); end
    endtask

    task automatic test_round_robin();
        logic exp0;
        logic prev0;
        m1_write(32'h10, 32'h11111111, 4'hF);
        m1_write(32'h20, 32'h22222222, 4'hF);
        set_m0(1'b0, 4'hF, 32'h10, 32'h0);
        set_m1(1'b0, 4'hF, 32'h20, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp0  = (i % 2 == 0);
            prev0 = ((i - 1) % 2 == 0);
            @(negedge clk);
            checks++; if (m0_gnt !== exp0) begin errors++; $display("FAIL rr_m0_gnt[%0d] got %b exp %b", i, m0_gnt, exp0); end
            checks++; if (m1_gnt !== !exp0) begin errors++; $display("FAIL rr_m1_gnt[%0d] got %b exp %b", i, m1_gnt, !exp0); end
            checks++; if (mem_addr !== (exp0 ? 32'h10 : 32'h20)) begin errors++; $display("FAIL rr_addr[%0d] got %h", i, mem_addr); end
            if (i > 0) begin
                checks++; if (m0_rvalid !== prev0) begin errors++; $display("FAIL rr_m0_rvalid[%0d] got %b exp %b", i, m0_rvalid, prev0); end
                checks++; if (m1_rvalid !== !prev0) begin errors++; $display("FAIL rr_m1_rvalid[%0d] got %b exp %b", i, m1_rvalid, !prev0); end
            end
            tick();
        end
        idle();
        checks++; if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0) begin errors++; $display("FAIL rr_last_rvalid got m0=%b m1=%b exp m0=0 m1=1", m0_rvalid, m1_rvalid); end
        checks++; if (m0_rdata !== 32'h11111111) begin errors++; $display("FAIL rr_m0_rdata got %h exp 11111111", m0_rdata); end
        checks++; if (m1_rdata !== 32'h22222222) begin errors++; $display("FAIL rr_m1_rdata got %h exp 22222222", m1_rdata); end
    endtask

    task automatic test_byte_write();
        m1_write(32'h80, 32'h11223344, 4'hF);
        set_m1(1'b1, 4'b0010, 32'h80, 32'h0000AB00, 1'b0);
        @(negedge clk);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL bw_mem_we got %b exp 1", mem_we); end
        checks++; if (mem_be !== 4'b0010) begin errors++; $display("FAIL bw_mem_be got %b exp 0010", mem_be); end
        checks++; if (mem_wd !== 32'h0000AB00) begin errors++; $display("FAIL bw_mem_wd got %h exp 0000ab00", mem_wd); end
        tick();
        idle();
        set_m0(1'b0, 4'hF, 32'h80, 32'h0);
        tick();
        idle();
        checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL bw_rvalid got %b exp 1", m0_rvalid); end
        checks++; if (m0_rdata !== 32'h1122AB44) begin errors++; $display("FAIL bw_rdata got %h exp 1122ab44", m0_rdata); end
    endtask

    task automatic test_lock_break();
        logic exp0;
        idle();
        set_m1(1'b0, 4'hF, 32'h40, 32'h0, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            if (c == 2) set_m0(1'b0, 4'hF, 32'h80, 32'h0);
            exp0 = (c == 6);
            @(negedge clk);
            checks++; if (m0_gnt !== exp0) begin errors++; $display("FAIL lock_m0_gnt[%0d] got %b exp %b", c, m0_gnt, exp0); end
            checks++; if (m1_gnt !== !exp0) begin errors++; $display("FAIL lock_m1_gnt[%0d] got %b exp %b", c, m1_gnt, !exp0); end
            if (c == 2) begin
                checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lock_m1_read got v=%b d=%h exp v=1 d=deadbeef", m1_rvalid, m1_rdata); end
            end
            tick();
        end
        checks++; if (dut.r_lock !== 1'b0) begin errors++; $display("FAIL break_lock_q got %b exp 0", dut.r_lock); end
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h1122AB44) begin errors++; $display("FAIL break_m0_read got v=%b d=%h exp v=1 d=1122ab44", m0_rvalid, m0_rdata); end
        m1_lock = 0;
        for (int c = 7; c <= 9; c++) begin
            exp0 = (c == 8);
            @(negedge clk);
            checks++; if (m0_gnt !== exp0) begin errors++; $display("FAIL post_m0_gnt[%0d] got %b exp %b", c, m0_gnt, exp0); end
            checks++; if (m1_gnt !== !exp0) begin errors++; $display("FAIL post_m1_gnt[%0d] got %b exp %b", c, m1_gnt, !exp0); end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid_burst();
        idle();
        set_m1(1'b0, 4'hF, 32'h10, 32'h0, 1'b1);
        @(negedge clk);
        checks++; if (m1_gnt !== 1'b1) begin errors++; $display("FAIL burst_m1_gnt got %b exp 1", m1_gnt); end
        tick();
        reset = 0;
        @(negedge clk);
        checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL midrst_m1_gnt got %b exp 0", m1_gnt); end
        tick();
        checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_m1_rvalid got %b exp 0", m1_rvalid); end
        checks++; if (m1_rdata !== 32'h0) begin errors++; $display("FAIL midrst_m1_rdata got %h exp 0", m1_rdata); end
        reset = 1;
        set_m0(1'b0, 4'hF, 32'h40, 32'h0);
        @(negedge clk);
        checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL after_rst_m0_gnt got %b exp 1", m0_gnt); end
        checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL after_rst_m1_gnt got %b exp 0", m1_gnt); end
        tick();
        idle();
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL after_rst_read got v=%b d=%h exp v=1 d=deadbeef", m0_rvalid, m0_rdata); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_byte_write();
        test_lock_break();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
